// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS execute-stage multiply/divide unit.
//   - op encodings for MULT / MULTU / DIV / DIVU
//   - FSM state enumeration (IDLE, ITER, FIX)
//   - default datapath width and the divide-by-zero quotient value
package mips_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Quotient returned for any divide by zero at the default width.
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // True for the signed operations (MULT, DIV).
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the control/issue logic and
// the multiply/divide unit.
//   master (issue side): drives start, op, rs, rt, mthi, mtlo; reads busy, done, hi, lo
//   slave  (unit side) : the reverse
interface muldiv_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration over the 2*WIDTH accumulator.
//   is_div   in  1        0: shift-add multiply step, 1: restoring divide step
//   acc      in  2*WIDTH  accumulator {upper, lower}
//   operand  in  WIDTH    multiplicand magnitude (mul) or divisor magnitude (div)
//   acc_next out 2*WIDTH  accumulator after this iteration
//
// Multiply: lower half starts as the multiplier; each step adds the
//   multiplicand to the upper half when the multiplier LSB is set, then the
//   whole accumulator shifts right (carry enters at the top).
// Divide: upper half is the partial remainder, lower half starts as the
//   dividend and fills with quotient bits from the right.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Multiply: carry out of the add becomes the new top bit after the shift.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {sum, acc[WIDTH-1:1]};

    // Divide: bring the next dividend bit into the remainder and trial-subtract.
    // The extra top bit keeps the shifted remainder exact; a clear sign bit on
    // the difference means the divisor fits.
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    diff      = rem_shift - {1'b0, operand};
    fits      = ~diff[WIDTH];
    new_rem   = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    div_next  = {new_rem, acc[WIDTH-2:0], fits};

    acc_next = is_div ? div_next : mul_next;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle integer multiply/divide with HI/LO registers.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    slave side of muldiv_unit_if:
//            start/op/rs/rt  launch an operation (honoured only in IDLE)
//            mthi/mtlo       copy rs into HI/LO (IDLE only, start wins)
//            busy            high for the WIDTH+1 cycles of an operation
//            done            one-cycle pulse after HI/LO take a result
//            hi/lo           architectural HI/LO registers
//
// Operands are reduced to magnitudes at start; the WIDTH iterations run
// unsigned and the FIX state applies the sign rules while writing HI/LO, so
// hi/lo never show intermediate values.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ITER = ITER;
  localparam logic [1:0] S_FIX  = FIX;

  logic [1:0]         state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   m_reg;        // multiplicand or divisor magnitude
  logic               is_div_reg;
  logic               neg_q_reg;    // negate product / quotient
  logic               neg_r_reg;    // negate remainder (dividend was negative)
  logic               div_zero_reg;
  logic [WIDTH-1:0]   rs_raw_reg;   // original dividend, returned in HI on divide by zero
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // Start-time operand conditioning
  logic               start_signed;
  logic               start_div;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;

  // Iteration and fix-up
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    start_signed = op_is_signed(bus.op);
    start_div    = bus.op[1];
    rs_neg       = start_signed & bus.rs[WIDTH-1];
    rt_neg       = start_signed & bus.rt[WIDTH-1];
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    rs_abs       = rs_neg ? -bus.rs : bus.rs;
    rt_abs       = rt_neg ? -bus.rt : bus.rt;
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .operand  (m_reg),
    .acc_next (step_acc)
  );

  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      m_reg        <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      rs_raw_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            // Multiply keeps the multiplier in the lower half; divide keeps
            // the dividend there. The other operand sits in m_reg.
            acc_reg      <= start_div ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
            m_reg        <= start_div ? rt_abs : rs_abs;
            is_div_reg   <= start_div;
            neg_q_reg    <= rs_neg ^ rt_neg;
            neg_r_reg    <= rs_neg;
            div_zero_reg <= (bus.rt == '0);
            rs_raw_reg   <= bus.rs;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= S_ITER;
          end else begin
            if (bus.mthi) hi_reg <= bus.rs;
            if (bus.mtlo) lo_reg <= bus.rs;
          end
        end
        S_ITER: begin
          acc_reg   <= step_acc;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_ITER) state_reg <= S_FIX;
        end
        S_FIX: begin
          if (!is_div_reg) begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end else if (div_zero_reg) begin
            hi_reg <= rs_raw_reg;
            lo_reg <= {WIDTH{1'b1}};
          end else begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic model of MULT/MULTU/DIV/DIVU, plus latency, handshake,
// move and reset behaviour.
module tb_muldiv_unit;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: HI/LO from the architectural definition of each op.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint     sp;
    logic [63:0] up;
    int         sa;
    int         sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULT: begin
        sp = longint'(sa) * longint'(sb);
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one operation and follow it to completion. inject pulses
  // start/mthi/mtlo with junk mid-operation; with_move raises mtlo together
  // with start.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, input bit with_move);
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] lo_before;
    int          edges;
    int          busy_cycles;
    ref_model(op, a, b, exp_hi, exp_lo);
    @(negedge clk);
    lo_before = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    bus.mtlo  = with_move;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mtlo  = 1'b0;
    if (with_move) check("start_beats_mtlo", {32'd0, bus.lo}, {32'd0, lo_before});
    edges       = 0;
    busy_cycles = 0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cycles++;
      if (inject && edges == 10) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.op    = ~op;
        bus.rs    = $urandom;
        bus.rt    = $urandom;
      end
      if (inject && edges == 11) begin
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    check("done_seen", {63'd0, bus.done}, 64'd1);
    check("latency", 64'(edges), 64'd33);
    check("busy_cycles", 64'(busy_cycles), 64'd33);
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    check("hi", {32'd0, bus.hi}, {32'd0, exp_hi});
    check("lo", {32'd0, bus.lo}, {32'd0, exp_lo});
    $display("[TB] op=%0d rs=%h rt=%h -> hi=%h lo=%h edges=%0d", op, a, b, bus.hi, bus.lo, edges);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs    = '0;
    bus.rt    = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases from the datapath corners
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         0, 0);
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 0, 0);
    do_op(OP_DIVU,  32'd100,       32'd7,         0, 0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(OP_DIVU,  32'd5,         32'd0,         0, 0);
    do_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         0, 0);

    // Requests arriving mid-operation must not disturb it
    do_op(OP_DIV,   32'd1000,      32'hFFFF_FFFD, 1, 0);
    do_op(OP_MULT,  32'h1234_5678, 32'hFEDC_BA98, 1, 0);

    // Register moves in IDLE
    @(negedge clk);
    bus.mthi = 1'b1;
    bus.rs   = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
    check("mthi_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    bus.rs   = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("both_hi", {32'd0, bus.hi}, 64'hCAFE_F00D);
    check("both_lo", {32'd0, bus.lo}, 64'hCAFE_F00D);
    $display("[TB] moves hi=%h lo=%h", bus.hi, bus.lo);

    // mtlo together with start: only the result reaches LO
    do_op(OP_MULTU, 32'd7, 32'd9, 0, 1);

    // Randomized operations, issued back-to-back in the done cycle
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0), 0);
    end

    // Reset 10 cycles into a DIV abandons it immediately
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.rs    = 32'd77;
    bus.rt    = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_idle_busy", {63'd0, bus.busy}, 64'd0);
    $display("[TB] reset mid-DIV: hi=%h lo=%h dones=%0d", bus.hi, bus.lo, dones);

    // Unit still works after the abandoned operation
    do_op(OP_DIVU, 32'd77, 32'd5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle integer multiply/divide unit with HI/LO registers for the 32-bit MIPS datapath. It sits in the execute stage beside the ALU. It takes rs/rt operands from the register-file read ports and drives HI/LO to the writeback-select 2:1 muxes, which serve MFHI/MFLO. The control unit stalls issue while `busy` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; one clock domain
- `start`  in  1  begin operation `op` on `rs`/`rt`; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs`  in  WIDTH  multiplicand/dividend; data source for MTHI/MTLO
- `rt`  in  WIDTH  multiplier/divisor
- `mthi`  in  1  write `rs` into HI (IDLE only)
- `mtlo`  in  1  write `rs` into LO (IDLE only)
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse: HI/LO just updated by an operation
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
States:
- IDLE: `start` loads operand registers, clears the iteration counter and goes to ITER.
- ITER: `WIDTH` iterations, one per cycle; counter 0..WIDTH-1; goes to FIX after the last iteration.
- FIX: sign correction and HI/LO write; returns to IDLE.

Signed ops (MULT, DIV):
- The unit latches absolute values plus sign flags at start.
- Product is negated if the operand signs differ.
- Quotient is negated if the operand signs differ.
- Remainder takes the sign of the dividend.

Datapaths:
- Multiply: shift-add over the 64-bit {HI,LO} accumulator. HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per iteration. LO = quotient, HI = remainder.

Corner cases:
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `rs` unmodified, no sign fix.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0 (two's-complement wrap).

Input rules:
- `start` outside IDLE is ignored.
- `mthi`/`mtlo` outside IDLE are ignored.
- In IDLE, `start` takes precedence over `mthi`/`mtlo` in the same cycle; the moves are dropped.
- `mthi` and `mtlo` together both write `rs`.
- HI/LO are never partially updated during ITER. Outputs hold their previous values until FIX.

## Timing
- Reset, asynchronous and immediate, including mid-operation: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. An in-flight operation is abandoned.
- `start` is sampled at edge E0. `busy`=1 from after E0 until after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Edge E0+WIDTH+1 (E33) writes HI/LO. `done`=1 and `busy`=0 during the following cycle only.
- Latency from `start` edge to valid HI/LO: WIDTH+1 edges. The same for all four ops, including divide-by-zero.
- A new `start` is accepted in the same cycle `done` is high (state is IDLE).
- MTHI/MTLO: register updates at the sampling edge, 1-cycle latency, and `done` stays 0.
- `busy` and `done` are registered outputs, with no combinational path from inputs.

## Structure
- Shared package `mips_pkg`:
  - `op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state enum (IDLE, ITER, FIX)
  - `WIDTH`=32 default
  - divide-by-zero quotient constant 0xFFFFFFFF
- Sub-module `muldiv_step`: combinational single iteration, selecting between the shift-add step and the restore-subtract step by an `is_div` flag. The top level holds the FSM, counter, operand/sign registers and HI/LO.

## Test plan
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` exactly 33 edges after the `start` edge; `busy` high 33 cycles.
2. MULT -3 (0xFFFFFFFD) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
3. DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
4. DIVU 5/0 and DIV -5/0 -> LO=0xFFFFFFFF, HI=`rs`; same latency as other ops.
5. `start` or `mthi` pulsed mid-operation -> ignored, result unchanged. Reset asserted 10 cycles into a DIV -> `busy`/`done`/`hi`/`lo` all 0 immediately, no later `done`.
6. IDLE MTHI `rs`=0x1234 -> `hi`=0x1234 next cycle, `done`=0. MTLO together with `start` -> `lo` not written by the move; LO gets only the operation result. Back-to-back `start` in the `done` cycle is accepted.
